isi_channel_emulator: RTL

//  Successor stimulus block for MER measurement. Models an N-tap ISI channel on the symbol stream.

---
 rtl/mer_dsp_pkg.sv | 32 +++
 rtl/mer_err_pwr_acc.sv | 59 +++++
 rtl/isi_channel_emulator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mer_dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mer_dsp_pkg                                                     |
// | Purpose  : Shared 1sX constants, tap-index type and saturation helper.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mer_dsp_pkg;

    localparam int c_MAX_TAPS = 15;

    localparam logic signed [17:0] c_ONE  = 18'sd131071;
    localparam logic signed [17:0] c_HALF = 18'sd65536;

    typedef logic [$clog2(c_MAX_TAPS)-1:0] tap_idx_t;

    // Clamp a signed value into the range of a signed width-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                        input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mer_err_pwr_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mer_err_pwr_acc                                                 |
// | Purpose  : Windowed sum of error^2 over 2^ACC_LOG2 valid symbols.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mer_err_pwr_acc #(
    parameter int DATA_WIDTH = 18,
    parameter int ACC_LOG2   = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_en,
    input  logic                             sample_valid,
    input  logic signed [DATA_WIDTH-1:0]     error,
    output logic [2*DATA_WIDTH+ACC_LOG2-1:0] err_pwr,
    output logic                             err_pwr_valid
);

    localparam int c_PW = 2 * DATA_WIDTH;
    localparam int c_AW = c_PW + ACC_LOG2;

    logic signed [c_PW-1:0] w_sq;
    logic [c_AW-1:0]        w_next;
    logic [c_AW-1:0]        r_acc;
    logic [c_AW-1:0]        r_pwr;
    logic [ACC_LOG2-1:0]    r_cnt;
    logic                   r_valid;

    assign w_sq   = c_PW'(error) * c_PW'(error);
    assign w_next = r_acc + {{ACC_LOG2{1'b0}}, w_sq};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc   <= '0;
            r_pwr   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clk_en && sample_valid) begin
                r_cnt <= r_cnt + 1'b1;
                // Last sample of the window: publish and restart from zero.
                if (&r_cnt) begin
                    r_pwr   <= w_next;
                    r_valid <= 1'b1;
                    r_acc   <= '0;
                end else begin
                    r_acc <= w_next;
                end
            end
        end
    end

    assign err_pwr       = r_pwr;
    assign err_pwr_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/isi_channel_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : isi_channel_emulator                                            |
// | Purpose  : N-tap ISI channel (unity centre tap) producing decision,        |
// |            errorless decision and error; optional error power accumulator  |
// |            enabled by define MER_ERR_POWER_ACC_EN.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module isi_channel_emulator
    import mer_dsp_pkg::*;
#(
    parameter int DATA_WIDTH   = 18,
    parameter int NUM_TAPS     = 5,
    parameter int CHANNEL_GAIN = 1,
    parameter int ACC_LOG2     = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_en,
    input  logic signed [DATA_WIDTH-1:0]     in_data,
    input  logic                             coef_wr,
    input  logic [$clog2(NUM_TAPS)-1:0]      coef_addr,
    input  logic signed [DATA_WIDTH-1:0]     coef_data,
    input  logic                             coef_commit,
    output logic                             coef_busy,
    output logic signed [DATA_WIDTH-1:0]     decision_variable,
    output logic signed [DATA_WIDTH-1:0]     errorless_decision_variable,
    output logic signed [DATA_WIDTH-1:0]     error,
    output logic                             out_valid,
    output logic [2*DATA_WIDTH+ACC_LOG2-1:0] err_pwr,
    output logic                             err_pwr_valid
);

    localparam int c_CENTRE = (NUM_TAPS - 1) / 2;
    localparam int c_PW     = 2 * DATA_WIDTH;
    localparam int c_SW     = c_PW + $clog2(NUM_TAPS);
    localparam int c_IW     = c_SW - DATA_WIDTH + 1;
    localparam int c_FILL   = NUM_TAPS + 3;
    localparam int c_FW     = $clog2(c_FILL + 1);

    logic signed [DATA_WIDTH-1:0] r_dline  [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] r_shadow [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] r_active [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] w_coef   [NUM_TAPS];
    logic signed [c_PW-1:0]       r_prod   [NUM_TAPS];
    logic                         r_pending;
    logic                         w_commit_now;
    logic                         w_wr_ok;
    tap_idx_t                     w_addr;

    logic signed [c_SW-1:0]       w_acc_sum;
    logic signed [c_SW-1:0]       r_acc;
    logic signed [DATA_WIDTH-1:0] r_c_d1;
    logic signed [DATA_WIDTH-1:0] r_c_d2;
    logic signed [c_IW-1:0]       w_isi;
    logic signed [DATA_WIDTH-1:0] w_isi_sat;
    logic signed [DATA_WIDTH-1:0] w_error;
    logic signed [DATA_WIDTH-1:0] w_errless;
    logic signed [DATA_WIDTH:0]   w_dec_sum;
    logic signed [DATA_WIDTH-1:0] w_decision;
    logic signed [DATA_WIDTH-1:0] r_error;
    logic signed [DATA_WIDTH-1:0] r_errless;
    logic signed [DATA_WIDTH-1:0] r_decision;
    logic [c_FW-1:0]              r_fill;

    assign w_addr       = tap_idx_t'(coef_addr);
    assign w_wr_ok      = coef_wr && (w_addr != tap_idx_t'(c_CENTRE)) && (w_addr < tap_idx_t'(NUM_TAPS));
    assign w_commit_now = clk_en && (r_pending || coef_commit);

    // A commit enable feeds the freshly copied set straight into S1.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++)
            w_coef[k] = w_commit_now ? r_shadow[k] : r_active[k];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_shadow[coef_addr] <= coef_data;
            if (w_commit_now) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (coef_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_acc_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++)
            w_acc_sum = w_acc_sum + c_SW'(r_prod[k]);
    end

    assign w_isi      = r_acc[c_SW-1:DATA_WIDTH-1];
    assign w_isi_sat  = DATA_WIDTH'(sat_to_width(64'(w_isi), DATA_WIDTH));
    assign w_error    = w_isi_sat >>> CHANNEL_GAIN;
    assign w_errless  = r_c_d2 >>> CHANNEL_GAIN;
    assign w_dec_sum  = (DATA_WIDTH+1)'(w_error) + (DATA_WIDTH+1)'(w_errless);
    assign w_decision = DATA_WIDTH'(sat_to_width(64'(w_dec_sum), DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_dline[k] <= '0;
                r_prod[k]  <= '0;
            end
            r_acc      <= '0;
            r_c_d1     <= '0;
            r_c_d2     <= '0;
            r_error    <= '0;
            r_errless  <= '0;
            r_decision <= '0;
            r_fill     <= '0;
        end else if (clk_en) begin
            r_dline[0] <= in_data;
            for (int k = 1; k < NUM_TAPS; k++)
                r_dline[k] <= r_dline[k-1];
            for (int k = 0; k < NUM_TAPS; k++)
                r_prod[k] <= (k == c_CENTRE) ? '0 : c_PW'(r_dline[k]) * c_PW'(w_coef[k]);
            r_c_d1     <= r_dline[c_CENTRE];
            r_acc      <= w_acc_sum;
            r_c_d2     <= r_c_d1;
            r_error    <= w_error;
            r_errless  <= w_errless;
            r_decision <= w_decision;
            if (r_fill != c_FW'(c_FILL))
                r_fill <= r_fill + 1'b1;
        end
    end

    assign coef_busy                   = r_pending;
    assign error                       = r_error;
    assign errorless_decision_variable = r_errless;
    assign decision_variable           = r_decision;
    assign out_valid                   = (r_fill == c_FW'(c_FILL));

`ifdef MER_ERR_POWER_ACC_EN
    mer_err_pwr_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_LOG2   (ACC_LOG2)
    ) u_err_pwr_acc (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .sample_valid  (out_valid),
        .error         (r_error),
        .err_pwr       (err_pwr),
        .err_pwr_valid (err_pwr_valid)
    );
`else
    assign err_pwr       = '0;
    assign err_pwr_valid = 1'b0;
`endif

endmodule
`default_nettype wire
